// File: rtl/perf_sampler.sv
// perf_sampler: command front-end for the perf-counter register block.
// Issues ctrl writes and assembles coherent hi/lo/hi 64-bit snapshots.
module perf_sampler #(
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    output logic [7:0]  addr_o,
    output logic [2:0]  wdata_o,
    output logic        w_en_o,
    input  logic [31:0] rdata_i,
    output logic        smp_valid_o,
    input  logic        smp_ready_i,
    output logic [63:0] smp_cycle_o,
    output logic [63:0] smp_insn_o,
    output logic        smp_torn_o
);

    localparam logic [3:0] MAX_R     = 4'(MAX_RETRY);
    localparam logic [1:0] OP_SAMPLE = 2'd3;

    localparam logic [7:0] A_CTRL    = 8'h00;
    localparam logic [7:0] A_CYC_LO  = 8'h04;
    localparam logic [7:0] A_CYC_HI  = 8'h08;
    localparam logic [7:0] A_INSN_LO = 8'h10;
    localparam logic [7:0] A_INSN_HI = 8'h14;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CAPT,
        RESULT
    } state_t;

    state_t      state_q;
    logic [2:0]  slot_q;
    logic [3:0]  retry_q;
    logic        torn_q;
    logic [31:0] h1_q;
    logic [31:0] lo_q;
    logic [63:0] cyc_q;

    logic        cmd_fire;
    logic        mismatch;
    logic        do_retry;
    logic [2:0]  slot_next;
    logic [2:0]  slot_back;
    logic [7:0]  addr_next;
    logic [7:0]  addr_back;

    assign cmd_ready_o = (state_q == IDLE) && !smp_valid_o;
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign mismatch    = (h1_q != rdata_i);
    assign do_retry    = mismatch && (retry_q < MAX_R);
    assign slot_next   = slot_q + 3'd1;
    assign slot_back   = slot_q - 3'd2;

    // Slots 0..2 are the cycle hi/lo/hi triple, 3..5 the insn triple.
    function automatic logic [7:0] slot_addr(input logic [2:0] s);
        logic [7:0] a;
        a = A_CTRL;
        case (s)
            3'd0, 3'd2: a = A_CYC_HI;
            3'd1:       a = A_CYC_LO;
            3'd3, 3'd5: a = A_INSN_HI;
            3'd4:       a = A_INSN_LO;
            default:    a = A_CTRL;
        endcase
        return a;
    endfunction

    assign addr_next = slot_addr(slot_next);
    assign addr_back = slot_addr(slot_back);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            retry_q     <= '0;
            torn_q      <= 1'b0;
            h1_q        <= '0;
            lo_q        <= '0;
            cyc_q       <= '0;
            addr_o      <= A_CTRL;
            wdata_o     <= '0;
            w_en_o      <= 1'b0;
            smp_valid_o <= 1'b0;
            smp_cycle_o <= '0;
            smp_insn_o  <= '0;
            smp_torn_o  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_op_i == OP_SAMPLE) begin
                            state_q <= RD_ISSUE;
                            slot_q  <= '0;
                            retry_q <= '0;
                            torn_q  <= 1'b0;
                            addr_o  <= A_CYC_HI;
                        end else begin
                            state_q <= WRITE;
                            addr_o  <= A_CTRL;
                            wdata_o <= {1'b0, cmd_op_i};
                            w_en_o  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    w_en_o  <= 1'b0;
                    state_q <= IDLE;
                end
                RD_ISSUE: begin
                    state_q <= RD_CAPT;
                end
                RD_CAPT: begin
                    state_q <= RD_ISSUE;
                    case (slot_q)
                        3'd0, 3'd3: begin
                            h1_q   <= rdata_i;
                            slot_q <= slot_next;
                            addr_o <= addr_next;
                        end
                        3'd1, 3'd4: begin
                            lo_q   <= rdata_i;
                            slot_q <= slot_next;
                            addr_o <= addr_next;
                        end
                        default: begin
                            if (do_retry) begin
                                retry_q <= retry_q + 4'd1;
                                slot_q  <= slot_back;
                                addr_o  <= addr_back;
                            end else if (slot_q == 3'd2) begin
                                retry_q <= '0;
                                torn_q  <= torn_q | mismatch;
                                cyc_q   <= {rdata_i, lo_q};
                                slot_q  <= slot_next;
                                addr_o  <= addr_next;
                            end else begin
                                retry_q     <= '0;
                                state_q     <= RESULT;
                                smp_valid_o <= 1'b1;
                                smp_cycle_o <= cyc_q;
                                smp_insn_o  <= {rdata_i, lo_q};
                                smp_torn_o  <= torn_q | mismatch;
                            end
                        end
                    endcase
                end
                RESULT: begin
                    if (smp_ready_i) begin
                        smp_valid_o <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_sampler.sv
// Bench for perf_sampler: register-block model plus snapshot scoreboard.
// Covers writes, clean/torn samples, backpressure and async reset.
module tb_perf_sampler;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic        cmd_ready;
    logic [7:0]  addr_o;
    logic [2:0]  wdata_o;
    logic        w_en_o;
    logic [31:0] rdata = '0;
    logic        smp_valid;
    logic        smp_ready = 1'b0;
    logic [63:0] smp_cycle;
    logic [63:0] smp_insn;
    logic        smp_torn;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] cyc;
        logic [63:0] insn;
        logic        torn;
        int          lat;
    } exp_t;

    exp_t sb[$];

    // Counter-block model: mode 0 static, 1 single tear, 2 hi ticks per lookup
    int          mode = 0;
    logic        clr_req = 1'b0;
    int          nc = 0;
    int          ni = 0;
    logic [31:0] hi_c = '0, lo_c = '0, hi_i = '0, lo_i = '0;
    logic [7:0]  seen [12];
    logic        wen_seen;

    always #5 clk = ~clk;

    perf_sampler #(.MAX_RETRY(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .w_en_o      (w_en_o),
        .rdata_i     (rdata),
        .smp_valid_o (smp_valid),
        .smp_ready_i (smp_ready),
        .smp_cycle_o (smp_cycle),
        .smp_insn_o  (smp_insn),
        .smp_torn_o  (smp_torn)
    );

    always @(posedge clk) begin
        case (addr_o)
            8'h04: rdata <= lo_c;
            8'h10: rdata <= lo_i;
            8'h08: begin
                if (mode == 1)      rdata <= (nc == 0) ? 32'd5 : 32'd6;
                else if (mode == 2) rdata <= hi_c + 32'(nc);
                else                rdata <= hi_c;
                nc = clr_req ? 0 : nc + 1;
            end
            8'h14: begin
                if (mode == 2) rdata <= hi_i + 32'(ni);
                else           rdata <= hi_i;
                ni = clr_req ? 0 : ni + 1;
            end
            default: rdata <= '0;
        endcase
        if (clr_req) begin
            nc = 0;
            ni = 0;
        end
    end

    // Offer a command at a negedge; returns at the negedge of cycle 1.
    task automatic send(input logic [1:0] op);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        clr_req   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        clr_req   = 1'b0;
    endtask

    task automatic run_sample(input bit rec, input bit ack);
        exp_t e;
        int   n;
        wen_seen = 1'b0;
        send(2'd3);
        n = 1;
        while (!smp_valid && n < 300) begin
            if (rec && n <= 12) seen[n-1] = addr_o;
            if (w_en_o) wen_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        n_checks++;
        if (n !== e.lat) begin
            n_errors++;
            $display("FAIL latency: got %0d want %0d", n, e.lat);
        end
        n_checks++;
        if (smp_cycle !== e.cyc) begin
            n_errors++;
            $display("FAIL cycle: got %h want %h", smp_cycle, e.cyc);
        end
        n_checks++;
        if (smp_insn !== e.insn) begin
            n_errors++;
            $display("FAIL insn: got %h want %h", smp_insn, e.insn);
        end
        n_checks++;
        if (smp_torn !== e.torn) begin
            n_errors++;
            $display("FAIL torn: got %b want %b", smp_torn, e.torn);
        end
        n_checks++;
        if (wen_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL read_wen: got %b want 0", wen_seen);
        end
        if (ack) begin
            smp_ready = 1'b1;
            @(negedge clk);
            smp_ready = 1'b0;
            n_checks++;
            if (smp_valid !== 1'b0 || cmd_ready !== 1'b1
                || smp_cycle !== e.cyc || smp_insn !== e.insn) begin
                n_errors++;
                $display("FAIL handshake: valid=%b ready=%b cyc=%h want 0/1/%h",
                         smp_valid, cmd_ready, smp_cycle, e.cyc);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || smp_valid !== 1'b0 || w_en_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctl: ready=%b valid=%b wen=%b want 1/0/0",
                     cmd_ready, smp_valid, w_en_o);
        end
        n_checks++;
        if (addr_o !== 8'h00 || wdata_o !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_bus: addr=%h wdata=%0d want 00/0", addr_o, wdata_o);
        end
        n_checks++;
        if (smp_cycle !== 64'd0 || smp_insn !== 64'd0 || smp_torn !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_smp: cyc=%h insn=%h torn=%b want 0",
                     smp_cycle, smp_insn, smp_torn);
        end
    endtask

    task automatic test_write();
        logic [1:0] ops [3];
        ops[0] = 2'd1;
        ops[1] = 2'd2;
        ops[2] = 2'd0;
        for (int i = 0; i < 3; i++) begin
            send(ops[i]);
            n_checks++;
            if (w_en_o !== 1'b1 || addr_o !== 8'h00
                || wdata_o !== {1'b0, ops[i]} || cmd_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL write%0d: wen=%b addr=%h wdata=%0d rdy=%b want 1/00/%0d/0",
                         i, w_en_o, addr_o, wdata_o, cmd_ready, ops[i]);
            end
            @(negedge clk);
            n_checks++;
            if (w_en_o !== 1'b0 || cmd_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL write%0d_end: wen=%b rdy=%b want 0/1",
                         i, w_en_o, cmd_ready);
            end
        end
    endtask

    task automatic test_static();
        logic [7:0] exp_a [12];
        exp_a = '{8'h08, 8'h08, 8'h04, 8'h04, 8'h08, 8'h08,
                  8'h14, 8'h14, 8'h10, 8'h10, 8'h14, 8'h14};
        mode = 0;
        hi_c = 32'h1;
        lo_c = 32'h8000_0000;
        hi_i = 32'h2;
        lo_i = 32'h10;
        sb.push_back('{64'h0000_0001_8000_0000, 64'h0000_0002_0000_0010, 1'b0, 13});
        run_sample(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (seen[i] !== exp_a[i]) begin
                n_errors++;
                $display("FAIL addr_seq[%0d]: got %h want %h", i, seen[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_single_tear();
        mode = 1;
        lo_c = 32'h10;
        hi_i = 32'h2;
        lo_i = 32'h10;
        sb.push_back('{64'h0000_0006_0000_0010, 64'h0000_0002_0000_0010, 1'b0, 19});
        run_sample(1'b0, 1'b1);
    endtask

    // Both hi words move on every lookup: four triples per counter, last H2 = base+14.
    task automatic test_persistent_tear();
        mode = 2;
        hi_c = 32'h100;
        lo_c = 32'h55;
        hi_i = 32'h200;
        lo_i = 32'h66;
        sb.push_back('{64'h0000_010E_0000_0055, 64'h0000_020E_0000_0066, 1'b1, 49});
        run_sample(1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        mode = 0;
        hi_c = 32'h1;
        lo_c = 32'h8000_0000;
        hi_i = 32'h2;
        lo_i = 32'h10;
        sb.push_back('{64'h0000_0001_8000_0000, 64'h0000_0002_0000_0010, 1'b0, 13});
        run_sample(1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (smp_valid !== 1'b1 || cmd_ready !== 1'b0 || w_en_o !== 1'b0
                || addr_o !== 8'h14 || smp_cycle !== 64'h0000_0001_8000_0000
                || smp_insn !== 64'h0000_0002_0000_0010) begin
                n_errors++;
                $display("FAIL hold%0d: valid=%b rdy=%b wen=%b addr=%h want 1/0/0/14",
                         i, smp_valid, cmd_ready, w_en_o, addr_o);
            end
        end
        smp_ready = 1'b1;
        @(negedge clk);
        smp_ready = 1'b0;
        n_checks++;
        if (smp_valid !== 1'b0 || cmd_ready !== 1'b1 || w_en_o !== 1'b0) begin
            n_errors++;
            $display("FAIL release: valid=%b rdy=%b wen=%b want 0/1/0",
                     smp_valid, cmd_ready, w_en_o);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (w_en_o !== 1'b1 || wdata_o !== 3'd1 || cmd_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL queued_cmd: wen=%b wdata=%0d rdy=%b want 1/1/0",
                     w_en_o, wdata_o, cmd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        mode = 0;
        send(2'd3);
        repeat (6) @(negedge clk);
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || smp_valid !== 1'b0 || w_en_o !== 1'b0
            || addr_o !== 8'h00 || wdata_o !== 3'd0 || smp_cycle !== 64'd0
            || smp_insn !== 64'd0 || smp_torn !== 1'b0) begin
            n_errors++;
            $display("FAIL async_rst: rdy=%b valid=%b addr=%h wdata=%0d cyc=%h want reset values",
                     cmd_ready, smp_valid, addr_o, wdata_o, smp_cycle);
        end
        @(negedge clk);
        rst_i = 1'b0;
        sb.push_back('{64'h0000_0001_8000_0000, 64'h0000_0002_0000_0010, 1'b0, 13});
        run_sample(1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_write();
        test_static();
        test_single_tear();
        test_persistent_tear();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
